// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads Rn then Rm through a single regfile read port,
// forwards a same-cycle writeback, shifts B by one bit and hands A/B to the ALU.
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] rn,
  input  logic [ADDR_W-1:0] rm,
  input  logic [1:0]        shift,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2,
    HOLD = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rn_q, rm_q;
  shift_t            shift_q;
  logic [DATA_W-1:0] rd_val, shifted;
  logic              accept;

  // A command is taken in IDLE, or in HOLD on the same edge the result is consumed.
  assign accept = start && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign busy   = (state != IDLE);

  // A writeback landing on the capture edge must win over the stale read data.
  assign rd_val = (wb_en && (wb_addr == r_addr)) ? wb_data : r_data;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    r_addr    = '0;
    case (state)
      IDLE: if (accept) state_nxt = RD_A;
      RD_A: begin
        r_addr    = rn_q;
        state_nxt = RD_B;
      end
      RD_B: begin
        r_addr    = rm_q;
        state_nxt = HOLD;
      end
      HOLD: if (out_ready) state_nxt = accept ? RD_A : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shifted = rd_val;
    case (shift_q)
      SH_LSL1: shifted = {rd_val[DATA_W-2:0], 1'b0};
      SH_LSR1: shifted = {1'b0, rd_val[DATA_W-1:1]};
      SH_ASR1: shifted = {rd_val[DATA_W-1], rd_val[DATA_W-1:1]};
      default: shifted = rd_val;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rn_q      <= '0;
      rm_q      <= '0;
      shift_q   <= SH_NONE;
      a_out     <= '0;
      b_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rn_q    <= rn;
        rm_q    <= rm;
        shift_q <= shift_t'(shift);
      end
      if (state == RD_A) a_out <= rd_val;
      if (state == RD_B) begin
        b_out     <= shifted;
        out_valid <= 1'b1;
      end
      if ((state == HOLD) && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: the bench owns the regfile and predicts
// A/B as the register contents just after each capture edge, shifted arithmetically.
module tb_operand_fetch;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] rn, rm;
  logic [1:0]        shift;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              busy, out_valid, out_ready;
  logic [DATA_W-1:0] a_out, b_out;

  logic [DATA_W-1:0] rf [8];
  logic [DATA_W-1:0] last_a, last_b;
  int checks = 0;
  int errors = 0;

  operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rn(rn), .rm(rm), .shift(shift),
    .r_addr(r_addr), .r_data(r_data), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .a_out(a_out), .b_out(b_out)
  );

  always #5 clk = ~clk;

  // Behavioural regfile: combinational read, write at the rising edge.
  assign r_data = rf[r_addr];
  always @(posedge clk) if (wb_en) rf[wb_addr] <= wb_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [DATA_W-1:0] shf(input logic [DATA_W-1:0] x, input logic [1:0] op);
    int unsigned v;
    v = x;
    case (op)
      2'd1:    return DATA_W'((v * 2) % 65536);
      2'd2:    return DATA_W'(v / 2);
      2'd3:    return DATA_W'(v / 2 + ((v >= 32768) ? 32768 : 0));
      default: return x;
    endcase
  endfunction

  task automatic launch(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sh);
    start = 1'b1; rn = a; rm = b; shift = sh;
    tick();
    start = 1'b0;
    rn = $urandom_range(7); rm = $urandom_range(7); shift = $urandom_range(3);
  endtask

  // Runs RD_A and RD_B (DUT must be in RD_A), with an optional writeback in each cycle.
  task automatic fetch(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sh,
                       input logic wa_en, input logic [2:0] wa_addr, input logic [15:0] wa_data,
                       input logic wbb_en, input logic [2:0] wbb_addr, input logic [15:0] wbb_data);
    check("rda_busy", busy, 1);
    check("rda_valid", out_valid, 0);
    check("rda_addr", r_addr, a);
    wb_en = wa_en; wb_addr = wa_addr; wb_data = wa_data;
    tick();
    last_a = rf[a];
    check("rdb_addr", r_addr, b);
    wb_en = wbb_en; wb_addr = wbb_addr; wb_data = wbb_data;
    tick();
    wb_en = 1'b0;
    last_b = shf(rf[b], sh);
    check("res_valid", out_valid, 1);
    check("res_busy", busy, 1);
    check("res_a", a_out, last_a);
    check("res_b", b_out, last_b);
    check("hold_addr", r_addr, 0);
  endtask

  task automatic release_to_idle();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_valid", out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_a_kept", a_out, last_a);
    check("idle_b_kept", b_out, last_b);
  endtask

  initial begin
    logic       pending;
    logic [2:0] na, nb;
    logic [1:0] ns;
    for (int i = 0; i < 8; i++) rf[i] = '0;
    rst_n = 1'b0; start = 1'b0; rn = '0; rm = '0; shift = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_a", a_out, 0);
    check("rst_b", b_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", r_addr, 0);
    rst_n = 1'b1;
    rf[0] = 16'd5030; rf[5] = 16'hFFE2; rf[2] = 16'd32767; rf[3] = 16'h8000; rf[1] = 16'd0;
    tick();

    launch(0, 5, 2'b00);
    fetch(0, 5, 2'b00, 0, 0, 0, 0, 0, 0);
    check("t1_a", a_out, 16'd5030);
    check("t1_b", b_out, 16'hFFE2);
    release_to_idle();

    launch(2, 2, 2'b01); fetch(2, 2, 2'b01, 0, 0, 0, 0, 0, 0);
    check("lsl_b", b_out, 16'hFFFE);
    release_to_idle();
    launch(3, 3, 2'b10); fetch(3, 3, 2'b10, 0, 0, 0, 0, 0, 0);
    check("lsr_b", b_out, 16'h4000);
    release_to_idle();
    launch(3, 3, 2'b11); fetch(3, 3, 2'b11, 0, 0, 0, 0, 0, 0);
    check("asr_b", b_out, 16'hC000);
    release_to_idle();

    launch(1, 1, 2'b00); fetch(1, 1, 2'b00, 1, 1, 16'h1234, 0, 0, 0);
    check("fwd_a", a_out, 16'h1234);
    release_to_idle();

    // Stall in HOLD with start pulsed: nothing may move.
    launch(0, 5, 2'b00); fetch(0, 5, 2'b00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; rn = 3; rm = 3; shift = 2'b11;
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_busy", busy, 1);
      check("stall_a", a_out, 16'd5030);
      check("stall_b", b_out, 16'hFFE2);
    end
    // Back-to-back: accept and new command on the same edge.
    out_ready = 1'b1; start = 1'b1; rn = 5; rm = 0; shift = 2'b00;
    tick();
    out_ready = 1'b0; start = 1'b0;
    check("b2b_valid", out_valid, 0);
    fetch(5, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    check("b2b_a", a_out, 16'hFFE2);
    check("b2b_b", b_out, 16'd5030);
    release_to_idle();

    // Reset in RD_B aborts the command immediately.
    launch(0, 5, 2'b00);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_a", a_out, 0);
    check("abort_b", b_out, 0);
    check("abort_addr", r_addr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_no_valid", out_valid, 0);
    launch(0, 5, 2'b00); fetch(0, 5, 2'b00, 0, 0, 0, 0, 0, 0);
    check("after_rst_a", a_out, 16'd5030);
    release_to_idle();

    // Randomized commands, writebacks, stalls and back-to-back issue.
    pending = 1'b0;
    na = '0; nb = '0; ns = '0;
    for (int it = 0; it < 60; it++) begin
      if (!pending) begin
        na = $urandom_range(7); nb = $urandom_range(7); ns = $urandom_range(3);
        launch(na, nb, ns);
      end
      fetch(na, nb, ns,
            1'($urandom_range(1)), 3'($urandom_range(7)), 16'($urandom),
            1'($urandom_range(1)), 3'($urandom_range(7)), 16'($urandom));
      for (int s = $urandom_range(3); s > 0; s--) begin
        start = 1'($urandom_range(1));
        tick();
        check("rnd_stall_valid", out_valid, 1);
        check("rnd_stall_a", a_out, last_a);
        check("rnd_stall_b", b_out, last_b);
      end
      if ($urandom_range(1) == 1) begin
        na = $urandom_range(7); nb = $urandom_range(7); ns = $urandom_range(3);
        out_ready = 1'b1; start = 1'b1; rn = na; rm = nb; shift = ns;
        tick();
        out_ready = 1'b0; start = 1'b0;
        pending = 1'b1;
      end else begin
        start = 1'b0;
        release_to_idle();
        pending = 1'b0;
      end
    end
    if (pending) begin
      fetch(na, nb, ns, 0, 0, 0, 0, 0, 0);
      release_to_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
